// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
// Holds the FSM encoding, byte-enable patterns and the alignment rule.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam logic [3:0] BE_WORD    = 4'hF;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;

  localparam int STARVE_LIMIT_DEF = 4;

  // Words need addr[1:0]==0 and halves need addr[0]==0.
  // Every other enable pattern is treated as legal.
  function automatic logic is_misaligned(input logic [3:0] be, input logic [1:0] a_lo);
    case (be)
      BE_WORD:               return a_lo != 2'b00;
      BE_HALF_LO, BE_HALF_HI: return a_lo[0];
      default:               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch port, the data port, the memory and the arbiter.
// slave = arbiter view, master = requesters + memory view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;
  logic              i_err;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [3:0]        d_be;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;

  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [3:0]        m_be;
  logic              m_ready;
  logic [DATA_W-1:0] m_rdata;

  logic              busy;

  modport slave (
    input  i_req, i_addr,
    output i_ack, i_rdata, i_err,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    output d_ack, d_rdata, d_err,
    output m_req, m_we, m_addr, m_wdata, m_be,
    input  m_ready, m_rdata,
    output busy
  );

  modport master (
    output i_req, i_addr,
    input  i_ack, i_rdata, i_err,
    output d_req, d_we, d_addr, d_wdata, d_be,
    input  d_ack, d_rdata, d_err,
    input  m_req, m_we, m_addr, m_wdata, m_be,
    output m_ready, m_rdata,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter_align_chk.sv
// Combinational misalignment check for one requester port.
module mem_port_arbiter_align_chk
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] addr_lo,
  input  logic [3:0] be,
  output logic       misaligned
);
  assign misaligned = is_misaligned(be, addr_lo);
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and load/store onto one single-ported memory.
// Data has priority; a starvation counter forces a fetch grant at STARVE_LIMIT.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  arb_state_e        state, state_nxt;
  logic [3:0]        starve_cnt;
  logic              win_d;
  logic              err_dly;
  logic              i_mis, d_mis;
  logic              grant_i, grant_d, done;

  logic              m_req_q, m_we_q;
  logic [ADDR_W-1:0] m_addr_q;
  logic [DATA_W-1:0] m_wdata_q, i_rdata_q, d_rdata_q;
  logic [3:0]        m_be_q;
  logic              i_err_q, d_err_q;

  mem_port_arbiter_align_chk u_chk_i (
    .addr_lo    (bus.i_addr[1:0]),
    .be         (BE_WORD),
    .misaligned (i_mis)
  );

  mem_port_arbiter_align_chk u_chk_d (
    .addr_lo    (bus.d_addr[1:0]),
    .be         (bus.d_be),
    .misaligned (d_mis)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.i_req && (!bus.d_req || starve_cnt == LIM)) begin
          grant_i   = 1'b1;
          state_nxt = i_mis ? RESP : GNT_I;
        end else if (bus.d_req) begin
          grant_d   = 1'b1;
          state_nxt = d_mis ? RESP : GNT_D;
        end
      end
      GNT_I, GNT_D: begin
        if (bus.m_ready) begin
          done      = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        // error responses spend one silent cycle here so their ack lines up
        // with the zero-wait memory path
        if (!err_dly) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
      win_d      <= 1'b0;
      err_dly    <= 1'b0;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      m_be_q     <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      i_err_q    <= 1'b0;
      d_err_q    <= 1'b0;
    end else begin
      if (state == RESP) err_dly <= 1'b0;

      if (grant_i) begin
        win_d      <= 1'b0;
        starve_cnt <= '0;
        if (i_mis) begin
          i_err_q   <= 1'b1;
          i_rdata_q <= '0;
          err_dly   <= 1'b1;
        end else begin
          i_err_q   <= 1'b0;
          m_req_q   <= 1'b1;
          m_we_q    <= 1'b0;
          m_addr_q  <= bus.i_addr;
          m_wdata_q <= '0;
          m_be_q    <= BE_WORD;
        end
      end

      if (grant_d) begin
        win_d <= 1'b1;
        if (bus.i_req && starve_cnt != LIM) starve_cnt <= starve_cnt + 4'd1;
        if (d_mis) begin
          d_err_q   <= 1'b1;
          d_rdata_q <= '0;
          err_dly   <= 1'b1;
        end else begin
          d_err_q   <= 1'b0;
          m_req_q   <= 1'b1;
          m_we_q    <= bus.d_we;
          m_addr_q  <= bus.d_addr;
          m_wdata_q <= bus.d_wdata;
          m_be_q    <= bus.d_be;
        end
      end

      if (done) begin
        m_req_q <= 1'b0;
        if (!win_d)       i_rdata_q <= bus.m_rdata;
        else if (!m_we_q) d_rdata_q <= bus.m_rdata;
      end
    end
  end

  assign bus.i_ack   = (state == RESP) && !err_dly && !win_d;
  assign bus.d_ack   = (state == RESP) && !err_dly &&  win_d;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.i_err   = i_err_q;
  assign bus.d_err   = d_err_q;
  assign bus.m_req   = m_req_q;
  assign bus.m_we    = m_we_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.m_be    = m_be_q;
  assign bus.busy    = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs driven and outputs sampled on negedge.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    int          n;
    logic [5:0]  seq;
    logic [3:0]  cnt_at_i, cnt_at_d4;
    logic [31:0] addr0;

    reset = 1'b1;
    bus.i_req = 0; bus.i_addr = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0; bus.d_be = 0;
    bus.m_ready = 1; bus.m_rdata = 0;
    cyc(); cyc();
    chk("rst_busy",  32'(bus.busy),  0);
    chk("rst_mreq",  32'(bus.m_req), 0);
    chk("rst_acks",  32'({bus.i_ack, bus.d_ack}), 0);
    chk("rst_mbe",   32'(bus.m_be),  0);
    chk("rst_irdat", bus.i_rdata,    0);
    reset = 1'b0;

    // fetch only, zero-wait memory
    bus.i_req = 1; bus.i_addr = 32'h0040_0000; bus.m_rdata = 32'h2008_0005;
    cyc();
    chk("f_mreq",  32'(bus.m_req), 1);
    chk("f_mwe",   32'(bus.m_we),  0);
    chk("f_mbe",   32'(bus.m_be),  32'hF);
    chk("f_maddr", bus.m_addr,     32'h0040_0000);
    chk("f_iack0", 32'(bus.i_ack), 0);
    cyc();
    chk("f_iack",  32'(bus.i_ack), 1);
    chk("f_rdata", bus.i_rdata,    32'h2008_0005);
    chk("f_dack",  32'(bus.d_ack), 0);
    bus.i_req = 0;
    cyc();
    chk("f_ackw",  32'(bus.i_ack), 0);
    chk("f_idle",  32'(bus.busy),  0);

    // simultaneous: data store first, fetch three cycles later
    bus.i_req = 1; bus.i_addr = 32'h0040_0004;
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h1000_0004;
    bus.d_wdata = 32'hDEAD_BEEF; bus.d_be = 4'hF; bus.m_rdata = 32'h1111_2222;
    cyc();
    chk("s_mwe",   32'(bus.m_we),  1);
    chk("s_mbe",   32'(bus.m_be),  32'hF);
    chk("s_maddr", bus.m_addr,     32'h1000_0004);
    chk("s_wdata", bus.m_wdata,    32'hDEAD_BEEF);
    cyc();
    chk("s_dack",  32'({bus.i_ack, bus.d_ack}), 32'b01);
    chk("s_drd",   bus.d_rdata, 0);
    bus.d_req = 0;
    cyc();
    chk("s_gap",   32'(bus.m_req), 0);
    cyc();
    chk("s_imaddr", bus.m_addr, 32'h0040_0004);
    cyc();
    chk("s_iack",  32'({bus.i_ack, bus.d_ack}), 32'b10);
    chk("s_irdat", bus.i_rdata, 32'h1111_2222);
    bus.i_req = 0;
    cyc();

    // starvation: data re-requests back to back while fetch waits
    bus.i_req = 1; bus.i_addr = 32'h0040_0008;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h1000_0008; bus.d_be = 4'hF;
    n = 0; seq = '0; cnt_at_i = 4'hF; cnt_at_d4 = 4'hF;
    for (int c = 0; c < 60 && n < 6; c++) begin
      cyc();
      if (bus.d_ack) begin
        seq = {seq[4:0], 1'b0}; n++;
        if (n == 4) cnt_at_d4 = dut.starve_cnt;
      end else if (bus.i_ack) begin
        seq = {seq[4:0], 1'b1}; n++;
        cnt_at_i = dut.starve_cnt;
      end
    end
    chk("st_count", n, 6);
    chk("st_order", 32'(seq), 32'b000010);
    chk("st_cnt4",  32'(cnt_at_d4), 4);
    chk("st_clr",   32'(cnt_at_i),  0);
    bus.i_req = 0; bus.d_req = 0;
    cyc();

    // wait states on a load
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h1000_0010; bus.d_be = 4'hF;
    bus.m_ready = 0; bus.m_rdata = 32'hCAFE_0001;
    cyc();
    addr0 = bus.m_addr;
    chk("w_addr", addr0, 32'h1000_0010);
    for (int k = 0; k < 5; k++) begin
      chk("w_hold", 32'({bus.m_req, bus.m_we, bus.m_be, bus.d_ack}), 32'b1_0_1111_0);
      chk("w_stab", bus.m_addr, addr0);
      if (k < 4) cyc();
    end
    cyc();
    bus.m_ready = 1;
    cyc();
    chk("w_dack",  32'(bus.d_ack), 1);
    chk("w_rdata", bus.d_rdata,    32'hCAFE_0001);
    chk("w_derr",  32'(bus.d_err), 0);
    bus.d_req = 0;
    cyc();
    chk("w_width", 32'(bus.d_ack), 0);

    // misaligned word load
    bus.d_req = 1; bus.d_addr = 32'h1000_0002; bus.d_be = 4'hF;
    cyc();
    chk("md_mreq1", 32'({bus.m_req, bus.d_ack, bus.busy}), 32'b001);
    cyc();
    chk("md_ack",   32'({bus.m_req, bus.d_ack, bus.d_err}), 32'b011);
    chk("md_rdata", bus.d_rdata, 0);
    bus.d_req = 0;
    cyc();

    // halfword at addr[1]=1 is legal
    bus.d_req = 1; bus.d_addr = 32'h1000_0002; bus.d_be = 4'b0011;
    bus.m_rdata = 32'h0000_BEAD;
    cyc();
    chk("h_mreq", 32'({bus.m_req, bus.m_be}), 32'b1_0011);
    cyc();
    chk("h_ack",  32'({bus.d_ack, bus.d_err}), 32'b10);
    bus.d_req = 0;
    cyc();

    // misaligned fetch
    bus.i_req = 1; bus.i_addr = 32'h0040_0001;
    cyc();
    chk("mi_mreq", 32'({bus.m_req, bus.i_ack}), 0);
    cyc();
    chk("mi_ack",  32'({bus.m_req, bus.i_ack, bus.i_err}), 32'b011);
    bus.i_req = 0;
    cyc();

    // reset while waiting in GNT_D
    bus.d_req = 1; bus.d_addr = 32'h1000_0020; bus.d_be = 4'hF; bus.m_ready = 0;
    cyc();
    chk("r_gnt", 32'(bus.m_req), 1);
    reset = 1; bus.d_req = 0;
    cyc();
    chk("r_after", 32'({bus.m_req, bus.busy, bus.d_ack, bus.i_ack}), 0);
    reset = 0;
    cyc();
    chk("r_noack", 32'({bus.d_ack, bus.i_ack}), 0);
    bus.i_req = 1; bus.i_addr = 32'h0040_000C; bus.m_ready = 1; bus.m_rdata = 32'h0000_55AA;
    cyc();
    chk("r_mreq", 32'(bus.m_req), 1);
    cyc();
    chk("r_iack", 32'(bus.i_ack), 1);
    chk("r_rdat", bus.i_rdata, 32'h0000_55AA);
    bus.i_req = 0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
